// File: rtl/cfu_simd_mac_pkg.sv
// cfu_simd_mac_pkg: shared widths, funct3 opcode constants and FSM encoding
// for the packed-SIMD multiply-accumulate custom function unit.
package cfu_simd_mac_pkg;

  localparam int ACC_W = 32;
  localparam int OFF_W = 9;

  localparam logic [2:0] OP_XOR    = 3'd0;
  localparam logic [2:0] OP_MAC    = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_WRITE  = 3'd3;
  localparam logic [2:0] OP_SETOFF = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cfu_simd_mac_dot.sv
// cfu_simd_dot: signed SIMD dot product (A lanes plus offset, times B lanes),
// followed by STAGES register stages (0 = purely combinational).
module cfu_simd_dot
  import cfu_simd_mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int STAGES = 1
) (
  input  logic                    clk,
  input  logic [ACC_W-1:0]        a_i,
  input  logic [ACC_W-1:0]        b_i,
  input  logic signed [OFF_W-1:0] off_i,
  output logic [ACC_W-1:0]        dot_o
);

  localparam int OPA_W  = LANE_W + 2;
  localparam int PROD_W = 2 * LANE_W + 2;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [OPA_W-1:0]  opa;
    logic signed [LANE_W-1:0] opb;
    assign opa     = OPA_W'($signed(a_i[i*LANE_W +: LANE_W])) + OPA_W'(off_i);
    assign opb     = $signed(b_i[i*LANE_W +: LANE_W]);
    assign prod[i] = PROD_W'(opa) * PROD_W'(opb);
  end

  // NOTE: assign every always_comb output a default before any branch or loop so no latch is inferred.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
  end

  if (STAGES == 0) begin : g_comb
    assign dot_o = ACC_W'(sum);
  end else begin : g_pipe
    logic [ACC_W-1:0] pipe_q [STAGES];

    // NOTE: pure datapath stages carry no reset; the FSM never consumes them before they refill.
    // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
    always_ff @(posedge clk) begin
      pipe_q[0] <= ACC_W'(sum);
      for (int s = 1; s < STAGES; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end

    assign dot_o = pipe_q[STAGES-1];
  end

endmodule

// File: rtl/cfu_simd_mac.sv
// cfu_simd_mac: multi-cycle packed-SIMD signed MAC / XOR / accumulator CFU with
// valid-ready cmd and rsp channels. Define CFU_INPUT_OFFSET_EN for the SETOFF register.
module cfu_simd_mac
  import cfu_simd_mac_pkg::*;
#(
  parameter int LANES   = 4,   // LANES * LANE_W must equal 32
  parameter int LANE_W  = 8,
  parameter int MAC_LAT = 2    // >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int               CNT_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAC_LAT - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              op_q, op_d;
  logic [ACC_W-1:0]        a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]        acc_q, acc_d, out_q, out_d;
  logic [ACC_W-1:0]        dot;
  logic signed [OFF_W-1:0] off;
  logic                    exec_done;
  logic                    unused_funct7;

  assign unused_funct7 = ^cmd_payload_function_id[9:3];

`ifdef CFU_INPUT_OFFSET_EN
  logic signed [OFF_W-1:0] off_q, off_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) off_q <= '0;
    else        off_q <= off_d;
  end

  assign off = off_q;
`else
  assign off = '0;
`endif

  cfu_simd_dot #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .STAGES(MAC_LAT - 1)
  ) u_dot (
    .clk  (clk),
    .a_i  (a_q),
    .b_i  (b_q),
    .off_i(off),
    .dot_o(dot)
  );

  // Gating with reset keeps the unit from advertising readiness while held in reset.
  assign cmd_ready             = (state_q == IDLE) && reset;
  assign rsp_valid             = (state_q == RESP);
  assign rsp_payload_outputs_0 = out_q;
  assign exec_done             = (op_q == OP_MAC) ? (cnt_q == CNT_LAST) : 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
`ifdef CFU_INPUT_OFFSET_EN
    off_d   = off_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = EXEC;
          cnt_d   = '0;
          op_d    = cmd_payload_function_id[2:0];
          a_d     = cmd_payload_inputs_0;
          b_d     = cmd_payload_inputs_1;
        end
      end
      EXEC: begin
        if (exec_done) begin
          state_d = RESP;
          case (op_q)
            OP_XOR:   out_d = a_q ^ b_q;
            OP_MAC: begin
              acc_d = acc_q + dot;
              out_d = acc_q + dot;
            end
            OP_READ:  out_d = acc_q;
            OP_WRITE: begin
              acc_d = a_q;
              out_d = acc_q;
            end
`ifdef CFU_INPUT_OFFSET_EN
            OP_SETOFF: begin
              off_d = a_q[OFF_W-1:0];
              out_d = ACC_W'(off_q);
            end
`endif
            default:  out_d = '0;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_cfu_simd_mac.sv
// tb_cfu_simd_mac: directed self-checking bench for cfu_simd_mac (default MAC_LAT=2);
// follows CFU_INPUT_OFFSET_EN to pick the expected offset behaviour.
module tb_cfu_simd_mac;
  import cfu_simd_mac_pkg::*;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_fid   = '0;
  logic [31:0] in0       = '0;
  logic [31:0] in1       = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cfu_simd_mac #(
    .LANES  (4),
    .LANE_W (8),
    .MAC_LAT(2)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(cmd_fid),
    .cmd_payload_inputs_0   (in0),
    .cmd_payload_inputs_1   (in1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (rsp_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the unit idle; returns at posedge+1 in IDLE if rsp_ready,
  // otherwise still in RESP.
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input int exp_lat, input string tag);
    int n;
    cmd_valid = 1'b1;
    cmd_fid   = {7'h5A, op};
    in0       = a;
    in1       = b;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in0       = ~a;
    in1       = ~b;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_out"}, rsp_out, exp_out);
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int seen;
    logic [31:0] exp_mac_off;

    // Reset state, with a command offered during reset that must be ignored.
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_out", rsp_out, 32'd0);
    cmd_valid = 1'b1;
    cmd_fid   = {7'd0, OP_XOR};
    in0       = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    // XOR, accumulator untouched.
    do_cmd(OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_00FF, 32'hFFFF_F00F, 1, "xor");
    do_cmd(OP_READ, 32'h0, 32'h0, 32'h0000_0000, 1, "read_after_xor");

    // MAC accumulation.
    do_cmd(OP_WRITE, 32'h0, 32'h0, 32'h0000_0000, 1, "write0");
    do_cmd(OP_MAC, 32'h0102_0304, 32'h0101_0101, 32'h0000_000A, 2, "mac1");
    do_cmd(OP_MAC, 32'h0102_0304, 32'h0101_0101, 32'h0000_0014, 2, "mac2");
    do_cmd(OP_READ, 32'h0, 32'h0, 32'h0000_0014, 1, "read14");

    // Reserved opcodes return zero and change nothing.
    do_cmd(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, "op5");
    do_cmd(3'd7, 32'hFFFF_FFFF, 32'h0101_0101, 32'h0, 1, "op7");
    do_cmd(OP_READ, 32'h0, 32'h0, 32'h0000_0014, 1, "read_after_rsvd");

    // Signed lanes and wrap-around.
    do_cmd(OP_WRITE, 32'h0, 32'h0, 32'h0000_0014, 1, "write_old14");
    do_cmd(OP_MAC, 32'h0000_00FF, 32'h0000_0002, 32'hFFFF_FFFE, 2, "mac_neg");
    do_cmd(OP_WRITE, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFE, 1, "write_max");
    do_cmd(OP_MAC, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 2, "mac_wrap");
    do_cmd(OP_WRITE, 32'h0, 32'h0, 32'h8000_0000, 1, "write_old_wrap");
    do_cmd(OP_MAC, 32'h8080_8080, 32'h8080_8080, 32'h0001_0000, 2, "mac_minmin");

    // Backpressure: response held, busy unit ignores a new command.
    do_cmd(OP_WRITE, 32'h0, 32'h0, 32'h0001_0000, 1, "write_bp");
    rsp_ready = 1'b0;
    do_cmd(OP_MAC, 32'h0102_0304, 32'h0101_0101, 32'h0000_000A, 2, "mac_bp");
    cmd_valid = 1'b1;
    cmd_fid   = {7'd0, OP_WRITE};
    in0       = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_rsp_valid_%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_out_%0d", i), rsp_out, 32'h0000_000A);
      check($sformatf("bp_cmd_ready_%0d", i), 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
    do_cmd(OP_READ, 32'h0, 32'h0, 32'h0000_000A, 1, "read_after_bp");

    // Reset in the middle of a MAC's EXEC phase.
    cmd_valid = 1'b1;
    cmd_fid   = {7'd0, OP_MAC};
    in0       = 32'h0102_0304;
    in1       = 32'h0101_0101;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_exec_out", rsp_out, 32'd0);
    check("rst_exec_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("dropped_mac_no_rsp", 32'(seen), 32'd0);
    do_cmd(OP_READ, 32'h0, 32'h0, 32'h0000_0000, 1, "read_after_rst");

    // Reset while a response is being held.
    rsp_ready = 1'b0;
    do_cmd(OP_XOR, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1, "xor_pre_rst");
    reset = 1'b0;
    #1;
    check("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #3 reset     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_resp_cmd_ready", 32'(cmd_ready), 32'd1);

    // Input offset (or its absence).
`ifdef CFU_INPUT_OFFSET_EN
    exp_mac_off = 32'h0000_0000;
`else
    exp_mac_off = 32'hFFFF_FE00;
`endif
    do_cmd(OP_SETOFF, 32'h0000_0080, 32'h0, 32'h0000_0000, 1, "setoff");
    do_cmd(OP_WRITE, 32'h0, 32'h0, 32'h0000_0000, 1, "write_off");
    do_cmd(OP_MAC, 32'h8080_8080, 32'h0101_0101, exp_mac_off, 2, "mac_off");
`ifdef CFU_INPUT_OFFSET_EN
    do_cmd(OP_SETOFF, 32'h0000_01FF, 32'h0, 32'h0000_0080, 1, "setoff_old80");
    do_cmd(OP_SETOFF, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 1, "setoff_oldneg");
`else
    do_cmd(OP_SETOFF, 32'h0000_01FF, 32'h0, 32'h0000_0000, 1, "setoff_noop");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
